// File: rtl/riscv_pkg.sv
// Shared memory-map constants, response-source encoding and address helpers.
// The CPU core reuses this package.
package riscv_pkg;

  localparam logic [31:0] ENTRY     = 32'h8000_0000;
  localparam int unsigned MEM_WORDS = 2048;

  typedef enum logic [1:0] {
    RSP_NONE  = 2'd0,
    RSP_FETCH = 2'd1,
    RSP_DATA  = 2'd2
  } rsp_src_e;

  // 33-bit compare so a window ending at 2^32 cannot wrap
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] entry,
                                         input int unsigned words);
    logic [32:0] span_end;
    span_end = 33'(entry) + (33'(words) << 2);
    return (33'(addr) >= 33'(entry)) && (33'(addr) < span_end);
  endfunction

  function automatic logic [31:0] addr_to_word(input logic [31:0] addr,
                                               input logic [31:0] entry);
    return (addr - entry) >> 2;
  endfunction

endpackage

// File: rtl/mem_addr_check.sv
// Combinational range/alignment check and word-index translation for one requester.
module mem_addr_check #(
  parameter logic [31:0] ENTRY       = riscv_pkg::ENTRY,
  parameter int unsigned MEM_WORDS   = riscv_pkg::MEM_WORDS,
  parameter bit          CHECK_ALIGN = 1'b0
) (
  input  logic [31:0]                  addr,
  output logic                         ok_c,
  output logic [$clog2(MEM_WORDS)-1:0] idx_c
);
  import riscv_pkg::*;

  localparam int unsigned IW = $clog2(MEM_WORDS);

  always_comb begin
    idx_c = IW'(addr_to_word(addr, ENTRY));
    ok_c  = addr_in_range(addr, ENTRY, MEM_WORDS);
    if (CHECK_ALIGN && (addr[1:0] != 2'b00)) ok_c = 1'b0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a synchronous single-port RAM.
// Data has priority; fetch is forced through after STARVE_MAX consecutive losses.
module mem_arbiter #(
  parameter logic [31:0] ENTRY      = riscv_pkg::ENTRY,
  parameter int unsigned MEM_WORDS  = riscv_pkg::MEM_WORDS,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic [31:0]                  i_addr,
  input  logic                         d_valid,
  output logic                         d_ready,
  input  logic [31:0]                  d_addr,
  input  logic                         d_we,
  input  logic [3:0]                   d_be,
  input  logic [31:0]                  d_wdata,
  output logic                         i_rvalid,
  output logic                         d_rvalid,
  output logic [31:0]                  rsp_rdata,
  output logic                         rsp_err,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [3:0]                   mem_be,
  output logic [$clog2(MEM_WORDS)-1:0] mem_idx,
  output logic [31:0]                  mem_wdata,
  input  logic [31:0]                  mem_rdata
);
  import riscv_pkg::*;

  localparam int unsigned IW = $clog2(MEM_WORDS);
  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_q;
  logic          starved_c;
  logic          grant_i_c;
  logic          grant_d_c;
  logic          i_ok_c;
  logic          d_ok_c;
  logic [IW-1:0] i_idx_c;
  logic [IW-1:0] d_idx_c;
  logic          err_c;
  logic          use_mem_c;
  rsp_src_e      src_q;
  logic          err_q;
  logic          use_mem_q;

  mem_addr_check #(
    .ENTRY       (ENTRY),
    .MEM_WORDS   (MEM_WORDS),
    .CHECK_ALIGN (1'b1)
  ) u_i_check (
    .addr  (i_addr),
    .ok_c  (i_ok_c),
    .idx_c (i_idx_c)
  );

  mem_addr_check #(
    .ENTRY       (ENTRY),
    .MEM_WORDS   (MEM_WORDS),
    .CHECK_ALIGN (1'b0)
  ) u_d_check (
    .addr  (d_addr),
    .ok_c  (d_ok_c),
    .idx_c (d_idx_c)
  );

  // Grant is gated by reset so nothing is accepted while reset is held low
  always_comb begin
    starved_c = (starve_q == CW'(STARVE_MAX));
    grant_d_c = reset & d_valid & ~(i_valid & starved_c);
    grant_i_c = reset & i_valid & ~grant_d_c;
  end

  assign i_ready = grant_i_c;
  assign d_ready = grant_d_c;

  // RAM command for the granted requester; a zero-byte store never touches the RAM
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_idx   = '0;
    mem_wdata = '0;
    err_c     = 1'b0;
    use_mem_c = 1'b0;
    if (grant_d_c) begin
      mem_idx = d_idx_c;
      err_c   = ~d_ok_c;
      if (d_ok_c) begin
        mem_en    = ~d_we | (|d_be);
        mem_we    = d_we & (|d_be);
        mem_be    = d_we ? d_be : 4'b0000;
        mem_wdata = d_we ? d_wdata : 32'h0;
        use_mem_c = ~d_we;
      end
    end else if (grant_i_c) begin
      mem_idx   = i_idx_c;
      err_c     = ~i_ok_c;
      mem_en    = i_ok_c;
      use_mem_c = i_ok_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q  <= '0;
      src_q     <= RSP_NONE;
      err_q     <= 1'b0;
      use_mem_q <= 1'b0;
    end else begin
      if (i_valid && grant_d_c) starve_q <= starved_c ? starve_q : starve_q + CW'(1);
      else                      starve_q <= '0;
      src_q     <= grant_d_c ? RSP_DATA : (grant_i_c ? RSP_FETCH : RSP_NONE);
      err_q     <= err_c;
      use_mem_q <= use_mem_c;
    end
  end

  // RAM data arrives in the response cycle, so only the select is registered
  assign i_rvalid  = (src_q == RSP_FETCH);
  assign d_rvalid  = (src_q == RSP_DATA);
  assign rsp_err   = err_q;
  assign rsp_rdata = use_mem_q ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// scored against a request-level model with its own copy of the RAM contents.
module tb_mem_arbiter;

  localparam logic [31:0] ENTRY      = 32'h8000_0000;
  localparam int unsigned MEM_WORDS  = 2048;
  localparam int unsigned STARVE_MAX = 3;
  localparam int unsigned IW         = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid, i_ready, d_valid, d_ready, d_we;
  logic [31:0]   i_addr, d_addr, d_wdata;
  logic [3:0]    d_be;
  logic          i_rvalid, d_rvalid, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [IW-1:0] mem_idx;
  logic [31:0]   mem_wdata, mem_rdata;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] ram     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  bit          ram_init = 1'b0;

  mem_arbiter #(.ENTRY(ENTRY), .MEM_WORDS(MEM_WORDS), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr),
    .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
    .i_rvalid(i_rvalid), .d_rvalid(d_rvalid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_idx(mem_idx),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int k);
    return (32'(k) * 32'h9E37_79B9) ^ 32'h0000_0093;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (longint'(a) >= longint'(ENTRY)) && (longint'(a) < longint'(ENTRY) + 4 * longint'(MEM_WORDS));
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((longint'(a) - longint'(ENTRY)) / 4);
  endfunction

  // Synchronous single-port RAM; filled with a known pattern on the first edge
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int k = 0; k < int'(MEM_WORDS); k++) ram[k] <= init_word(k);
      ram_init <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int n = 0; n < 4; n++)
          if (mem_be[n]) ram[mem_idx][8*n +: 8] <= mem_wdata[8*n +: 8];
      end else begin
        mem_rdata <= ram[mem_idx];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_idle();
    i_valid = 1'b0; i_addr = 32'h0;
    d_valid = 1'b0; d_addr = 32'h0; d_we = 1'b0; d_be = 4'h0; d_wdata = 32'h0;
  endtask

  task automatic test_reset();
    i_valid = 1'b1; i_addr = ENTRY; d_valid = 1'b1; d_addr = ENTRY; d_we = 1'b1; d_be = 4'hF;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({i_ready, d_ready, mem_en, mem_we, mem_be} !== 8'h00) begin
      n_fail++; $display("FAIL reset_req: got %b want 00000000", {i_ready, d_ready, mem_en, mem_we, mem_be});
    end
    n_vec++;
    if ({i_rvalid, d_rvalid, rsp_err, rsp_rdata} !== 35'h0) begin
      n_fail++; $display("FAIL reset_rsp: got %b %b %b %h want 0 0 0 00000000", i_rvalid, d_rvalid, rsp_err, rsp_rdata);
    end
    @(posedge clk); #1;
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch_basic();
    @(posedge clk); #1;
    i_valid = 1'b1; i_addr = ENTRY;
    @(negedge clk);
    n_vec++;
    if ({i_ready, d_ready, mem_en, mem_we, mem_be, mem_idx} !== {4'b1010, 4'b0000, 11'd0}) begin
      n_fail++; $display("FAIL fetch_cmd: got rdy=%b en=%b we=%b be=%b idx=%0d want i_ready=1 en=1 we=0 be=0 idx=0",
                         {i_ready, d_ready}, mem_en, mem_we, mem_be, mem_idx);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_vec++;
    if ({i_rvalid, d_rvalid, rsp_err, rsp_rdata} !== {3'b100, 32'h0000_0093}) begin
      n_fail++; $display("FAIL fetch_rsp: got iv=%b dv=%b err=%b data=%h want 1 0 0 00000093", i_rvalid, d_rvalid, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    n_vec++;
    if ({i_rvalid, d_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_pulse: got %b want 00", {i_rvalid, d_rvalid});
    end
  endtask

  task automatic test_errors();
    @(posedge clk); #1;
    i_valid = 1'b1; i_addr = ENTRY + 32'h2000;
    @(negedge clk);
    n_vec++;
    if ({i_ready, mem_en} !== 2'b10) begin
      n_fail++; $display("FAIL err_oor_cmd: got rdy=%b en=%b want 1 0", i_ready, mem_en);
    end
    @(posedge clk); #1;
    i_addr = ENTRY + 32'h2;
    @(negedge clk);
    n_vec++;
    if ({i_rvalid, d_rvalid, rsp_err, rsp_rdata} !== {3'b101, 32'h0}) begin
      n_fail++; $display("FAIL err_oor_rsp: got %b %b %b %h want 1 0 1 00000000", i_rvalid, d_rvalid, rsp_err, rsp_rdata);
    end
    n_vec++;
    if ({i_ready, mem_en} !== 2'b10) begin
      n_fail++; $display("FAIL err_align_cmd: got rdy=%b en=%b want 1 0", i_ready, mem_en);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; d_valid = 1'b1; d_we = 1'b0; d_addr = ENTRY - 32'h4;
    @(negedge clk);
    n_vec++;
    if ({i_rvalid, d_rvalid, rsp_err, rsp_rdata} !== {3'b101, 32'h0}) begin
      n_fail++; $display("FAIL err_align_rsp: got %b %b %b %h want 1 0 1 00000000", i_rvalid, d_rvalid, rsp_err, rsp_rdata);
    end
    n_vec++;
    if ({d_ready, mem_en} !== 2'b10) begin
      n_fail++; $display("FAIL err_below_cmd: got rdy=%b en=%b want 1 0", d_ready, mem_en);
    end
    @(posedge clk); #1;
    d_addr = ENTRY + 32'(4 * (MEM_WORDS - 1)) + 32'h3;
    @(negedge clk);
    n_vec++;
    if ({i_rvalid, d_rvalid, rsp_err, rsp_rdata} !== {3'b011, 32'h0}) begin
      n_fail++; $display("FAIL err_below_rsp: got %b %b %b %h want 0 1 1 00000000", i_rvalid, d_rvalid, rsp_err, rsp_rdata);
    end
    n_vec++;
    if ({d_ready, mem_en, mem_idx} !== {2'b11, 11'd2047}) begin
      n_fail++; $display("FAIL last_word_cmd: got rdy=%b en=%b idx=%0d want 1 1 2047", d_ready, mem_en, mem_idx);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_vec++;
    if ({i_rvalid, d_rvalid, rsp_err, rsp_rdata} !== {3'b010, ref_mem[MEM_WORDS-1]}) begin
      n_fail++; $display("FAIL last_word_rsp: got %b %b %b %h want 0 1 0 %h", i_rvalid, d_rvalid, rsp_err, rsp_rdata, ref_mem[MEM_WORDS-1]);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] exp_word;
    @(posedge clk); #1;
    d_valid = 1'b1; d_we = 1'b1; d_addr = ENTRY + 32'h6; d_be = 4'b1100; d_wdata = 32'hABCD_0000;
    @(negedge clk);
    n_vec++;
    if ({d_ready, mem_en, mem_we, mem_be, mem_idx, mem_wdata} !== {3'b111, 4'b1100, 11'd1, 32'hABCD_0000}) begin
      n_fail++; $display("FAIL store_cmd: got rdy=%b en=%b we=%b be=%b idx=%0d wd=%h want 1 1 1 1100 1 abcd0000",
                         d_ready, mem_en, mem_we, mem_be, mem_idx, mem_wdata);
    end
    ref_mem[1][31:16] = 16'hABCD;
    exp_word = ref_mem[1];
    @(posedge clk); #1;
    d_we = 1'b0; d_addr = ENTRY + 32'h4; d_be = 4'b0000;
    @(negedge clk);
    n_vec++;
    if ({i_rvalid, d_rvalid, rsp_err, rsp_rdata} !== {3'b010, 32'h0}) begin
      n_fail++; $display("FAIL store_ack: got %b %b %b %h want 0 1 0 00000000", i_rvalid, d_rvalid, rsp_err, rsp_rdata);
    end
    n_vec++;
    if ({d_ready, mem_en, mem_we, mem_be} !== 7'b1100000) begin
      n_fail++; $display("FAIL load_cmd: got rdy=%b en=%b we=%b be=%b want 1 1 0 0000", d_ready, mem_en, mem_we, mem_be);
    end
    @(posedge clk); #1;
    d_we = 1'b1; d_be = 4'b0000; d_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_vec++;
    if ({i_rvalid, d_rvalid, rsp_err, rsp_rdata} !== {3'b010, exp_word}) begin
      n_fail++; $display("FAIL load_merge: got %b %b %b %h want 0 1 0 %h", i_rvalid, d_rvalid, rsp_err, rsp_rdata, exp_word);
    end
    n_vec++;
    if ({d_ready, mem_en} !== 2'b10) begin
      n_fail++; $display("FAIL store_be0_cmd: got rdy=%b en=%b want 1 0", d_ready, mem_en);
    end
    @(posedge clk); #1;
    d_we = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({i_rvalid, d_rvalid, rsp_err, rsp_rdata} !== {3'b010, 32'h0}) begin
      n_fail++; $display("FAIL store_be0_ack: got %b %b %b %h want 0 1 0 00000000", i_rvalid, d_rvalid, rsp_err, rsp_rdata);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_vec++;
    if (rsp_rdata !== exp_word) begin
      n_fail++; $display("FAIL store_be0_nowrite: got %h want %h", rsp_rdata, exp_word);
    end
  endtask

  task automatic test_starve();
    logic [1:0] exp_g;
    logic [1:0] prev_g = 2'b00;
    @(posedge clk); #1;
    i_valid = 1'b1; i_addr = ENTRY + 32'h8; d_valid = 1'b1; d_we = 1'b0; d_addr = ENTRY + 32'h10;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_g = ((c % 4) == 3) ? 2'b10 : 2'b01;
      n_vec++;
      if ({i_ready, d_ready} !== exp_g) begin
        n_fail++; $display("FAIL starve_grant cyc %0d: got %b want %b", c, {i_ready, d_ready}, exp_g);
      end
      if (c > 0) begin
        n_vec++;
        if ({i_rvalid, d_rvalid, rsp_rdata} !== {prev_g, (prev_g == 2'b10) ? ref_mem[2] : ref_mem[4]}) begin
          n_fail++; $display("FAIL starve_rsp cyc %0d: got %b %h want %b", c, {i_rvalid, d_rvalid}, rsp_rdata, prev_g);
        end
      end
      prev_g = exp_g;
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_g;
    @(posedge clk); #1;
    i_valid = 1'b1; i_addr = ENTRY + 32'h8; d_valid = 1'b1; d_we = 1'b0; d_addr = ENTRY + 32'hC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({i_ready, d_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_accept: got %b want 01", {i_ready, d_ready});
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({i_ready, d_ready, mem_en, mem_we, mem_be, i_rvalid, d_rvalid, rsp_err, rsp_rdata} !== 43'h0) begin
      n_fail++; $display("FAIL rstmid_zero: got rdy=%b en=%b we=%b be=%b rv=%b err=%b data=%h want all 0",
                         {i_ready, d_ready}, mem_en, mem_we, mem_be, {i_rvalid, d_rvalid}, rsp_err, rsp_rdata);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({i_rvalid, d_rvalid, rsp_err, rsp_rdata} !== 35'h0) begin
      n_fail++; $display("FAIL rstmid_suppress: got %b %b %b %h want 0 0 0 00000000", i_rvalid, d_rvalid, rsp_err, rsp_rdata);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_g = ((c % 4) == 3) ? 2'b10 : 2'b01;
      n_vec++;
      if ({i_ready, d_ready} !== exp_g) begin
        n_fail++; $display("FAIL rstmid_restart cyc %0d: got %b want %b", c, {i_ready, d_ready}, exp_g);
      end
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_random();
    bit          ip = 1'b0, dp = 1'b0, dwe = 1'b0;
    logic [31:0] ia = 32'h0, da = 32'h0, dw = 32'h0;
    logic [3:0]  dbe = 4'h0;
    int          losses = 0;
    int          r, k;
    bit          gi, gd, exp_en;
    logic [2:0]  exp_rsp = 3'b000;
    logic [31:0] exp_data = 32'h0;
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (!ip && $urandom_range(0, 3) != 0) begin
        ip = 1'b1;
        r  = int'($urandom_range(0, 9));
        if (r == 0)      ia = ENTRY + 32'h2000 + 32'(4 * $urandom_range(0, 15));
        else if (r == 1) ia = ENTRY + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
        else if (r == 2) ia = ENTRY - 32'(4 * $urandom_range(1, 4));
        else             ia = ENTRY + 32'(4 * $urandom_range(0, 63));
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp  = 1'b1;
        r   = int'($urandom_range(0, 9));
        if (r == 0)      da = ENTRY + 32'h2000 + 32'(4 * $urandom_range(0, 15));
        else if (r == 1) da = ENTRY - 32'(4 * $urandom_range(1, 4));
        else             da = ENTRY + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
        dwe = 1'($urandom_range(0, 1));
        dbe = 4'($urandom_range(0, 15));
        dw  = $urandom;
      end
      i_valid = ip; i_addr = ia;
      d_valid = dp; d_addr = da; d_we = dwe; d_be = dbe; d_wdata = dw;
      @(negedge clk);
      n_vec++;
      if ({i_rvalid, d_rvalid, rsp_err, rsp_rdata} !== {exp_rsp, exp_data}) begin
        n_fail++; $display("FAIL rnd_rsp cyc %0d: got iv=%b dv=%b err=%b data=%h want %b %h",
                           c, i_rvalid, d_rvalid, rsp_err, rsp_rdata, exp_rsp, exp_data);
      end
      gd = dp && !(ip && losses == int'(STARVE_MAX));
      gi = ip && !gd;
      exp_en = (gi && in_rng(ia) && ia[1:0] == 2'b00) || (gd && in_rng(da) && (!dwe || dbe != 4'h0));
      n_vec++;
      if ({i_ready, d_ready, mem_en} !== {gi, gd, exp_en}) begin
        n_fail++; $display("FAIL rnd_grant cyc %0d: got rdy=%b en=%b want %b %b", c, {i_ready, d_ready}, mem_en, {gi, gd}, exp_en);
      end
      losses   = (ip && gd) ? ((losses < int'(STARVE_MAX)) ? losses + 1 : losses) : 0;
      exp_rsp  = {gi, gd, 1'b0};
      exp_data = 32'h0;
      if (gi) begin
        if (!in_rng(ia) || ia[1:0] != 2'b00) exp_rsp[0] = 1'b1;
        else exp_data = ref_mem[idx_of(ia)];
        ip = 1'b0;
      end
      if (gd) begin
        k = idx_of(da);
        if (!in_rng(da)) exp_rsp[0] = 1'b1;
        else if (dwe) begin
          for (int n = 0; n < 4; n++) if (dbe[n]) ref_mem[k][8*n +: 8] = dw[8*n +: 8];
        end else exp_data = ref_mem[k];
        dp = 1'b0;
      end
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_vec++;
    if ({i_rvalid, d_rvalid, rsp_err, rsp_rdata} !== {exp_rsp, exp_data}) begin
      n_fail++; $display("FAIL rnd_last_rsp: got %b %b %b %h want %b %h", i_rvalid, d_rvalid, rsp_err, rsp_rdata, exp_rsp, exp_data);
    end
  endtask

  initial begin
    for (int k = 0; k < int'(MEM_WORDS); k++) ref_mem[k] = init_word(k);
    reset = 1'b0;
    drive_idle();
    test_reset();
    test_fetch_basic();
    test_errors();
    test_store_load();
    test_starve();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
